// File: rtl/spw_light_pio_pkg.sv
// -----------------------------------------------------------------------------
// spw_light_pio_pkg
// Shared constants for the SpaceWire light status PIO:
//   - Avalon word addresses of the register map
//   - edge-type selector values for the edge-capture logic
// -----------------------------------------------------------------------------
package spw_light_pio_pkg;

    // Register map (Avalon word addresses)
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    // Edge-type selector values
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Data-bus width of the Avalon slave
    localparam int PIO_BUS_W = 32;

endpackage : spw_light_pio_pkg

// File: rtl/spw_light_sync_bus.sv
// -----------------------------------------------------------------------------
// spw_light_sync_bus
// Multi-flop synchroniser for a bus of independent asynchronous bits. Each bit
// passes through STAGES flops clocked by clk_i; the chain clears to zero on a
// synchronous active-high reset.
//
// Ports:
//   clk_i    in   1      destination clock
//   reset_i  in   1      synchronous, active-high reset
//   data_i   in   WIDTH  asynchronous inputs
//   data_o   out  WIDTH  synchronised outputs (last chain stage)
// -----------------------------------------------------------------------------
module spw_light_sync_bus #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Synchroniser chain: stage 0 samples the asynchronous input, later
    // stages shift the value along to let metastability resolve.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[STAGES-1];

endmodule : spw_light_sync_bus

// File: rtl/spw_light_status_pio.sv
// -----------------------------------------------------------------------------
// spw_light_status_pio
// Avalon-MM input port for the SpaceWire light link status bundle. Samples
// WIDTH asynchronous status bits through a SYNC_STAGES-deep synchroniser,
// captures edges (rising / falling / any) into sticky write-1-to-clear flags,
// and raises a level interrupt when any captured flag is unmasked.
//
// Register map:
//   0 DATA     RO      synchronised inputs, zero-extended
//   1 reserved         reads 0, writes ignored
//   2 IRQMASK  RW      bits [WIDTH-1:0]
//   3 EDGECAP  RO/W1C  sticky edge flags
//
// Ports:
//   clk         in   1      system clock, rising edge
//   reset       in   1      synchronous, active-high, clears all state
//   address     in   2      Avalon word address
//   chipselect  in   1      Avalon select
//   write_n     in   1      Avalon write strobe, active low
//   writedata   in   32     Avalon write data
//   in_port     in   WIDTH  asynchronous status inputs
//   readdata    out  32     registered read data
//   irq         out  1      interrupt request, active-high level
// -----------------------------------------------------------------------------
module spw_light_status_pio
    import spw_light_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_s;
    logic             unused_wdata_s;

    // Bits of writedata above WIDTH are architecturally ignored.
    assign unused_wdata_s = ^writedata;

    spw_light_sync_bus #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .data_i  (in_port),
        .data_o  (sync_s)
    );

    assign wr_s = chipselect & ~write_n;

    // Per-bit edge detect between the synchronised value and its previous copy.
    always_comb begin
        edge_s = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_s = sync_s & ~prev_q;
            EDGE_FALL: edge_s = ~sync_s & prev_q;
            EDGE_ANY:  edge_s = sync_s ^ prev_q;
            default:   edge_s = '0;
        endcase
    end

    // IRQMASK next state: plain register write.
    always_comb begin
        mask_d = mask_q;
        if (wr_s && (address == PIO_ADDR_IRQMASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end else begin
            mask_d = mask_q;
        end
    end

    // EDGECAP next state: W1C clear first, then OR in new edges so that a
    // capture on the same cycle as a clear keeps the flag set.
    always_comb begin
        edgecap_d = edgecap_q;
        if (wr_s && (address == PIO_ADDR_EDGECAP)) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end else begin
            edgecap_d = edgecap_q;
        end
        edgecap_d = edgecap_d | edge_s;
    end

    // Read mux: evaluated every cycle regardless of chipselect; reads are
    // side-effect free so this is safe.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            PIO_ADDR_DATA:    readdata_d = 32'(sync_s);
            PIO_ADDR_RSVD:    readdata_d = 32'd0;
            PIO_ADDR_IRQMASK: readdata_d = 32'(mask_q);
            PIO_ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
            default:          readdata_d = 32'd0;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= 32'd0;
        end else begin
            prev_q     <= sync_s;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

    // Decoded from registers only, so the level cannot glitch.
    assign irq = |(edgecap_q & mask_q);

endmodule : spw_light_status_pio
